cpu_exec: RTL and testbench



---
 rtl/cpu_pkg.sv | 34 +++
 rtl/cpu_alu.sv | 34 +++
 rtl/cpu_exec.sv | 151 +++++++++++++++
 tb/tb_cpu_exec.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the cpu core and execute stage: opcodes, core states
// and flag bit positions.
package cpu_pkg;

   localparam logic [7:0] OP_NOP = 8'h00;
   localparam logic [7:0] OP_LDI = 8'h01;
   localparam logic [7:0] OP_MOV = 8'h02;
   localparam logic [7:0] OP_ADD = 8'h03;
   localparam logic [7:0] OP_SUB = 8'h04;
   localparam logic [7:0] OP_AND = 8'h05;
   localparam logic [7:0] OP_OR  = 8'h06;
   localparam logic [7:0] OP_XOR = 8'h07;
   localparam logic [7:0] OP_JMP = 8'h08;
   localparam logic [7:0] OP_JZ  = 8'h09;
   localparam logic [7:0] OP_JC  = 8'h0A;
   localparam logic [7:0] OP_JN  = 8'h0B;
   localparam logic [7:0] OP_OUT = 8'h0C;
   localparam logic [7:0] OP_HLT = 8'h0F;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_EXEC  = 2'd1,
      ST_HALT  = 2'd2
   } cpu_state_e;

   localparam int FLAG_Z = 0;
   localparam int FLAG_C = 1;
   localparam int FLAG_N = 2;

   function automatic logic is_alu_op(input logic [7:0] op);
      return (op >= OP_ADD) && (op <= OP_XOR);
   endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational 8-bit ALU: ADD/SUB/AND/OR/XOR with zero, carry/borrow and
// negative outputs.
module cpu_alu
   import cpu_pkg::*;
(
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic [7:0] op,
   output logic [7:0] result,
   output logic       z,
   output logic       c,
   output logic       n
);

   logic [8:0] wide;

   always_comb begin
      wide = 9'd0;
      case (op)
         OP_ADD:  wide = {1'b0, a} + {1'b0, b};
         // Bit 8 of the 9-bit difference is the borrow (a < b).
         OP_SUB:  wide = {1'b0, a} - {1'b0, b};
         OP_AND:  wide = {1'b0, a & b};
         OP_OR:   wide = {1'b0, a | b};
         OP_XOR:  wide = {1'b0, a ^ b};
         default: wide = 9'd0;
      endcase
      result = wide[7:0];
      c      = wide[8];
      z      = (wide[7:0] == 8'd0);
      n      = wide[7];
   end

endmodule

// File: rtl/cpu_exec.sv
// Execute stage: register file, operand latches, flags, output port and the
// sequencing controls returned to cpu_core.
module cpu_exec
   import cpu_pkg::*;
#(
   parameter int NREGS = 4
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] ir,
   input  logic [15:0] clks,
   input  logic [1:0]  state,
   input  logic        out_ready,
   output logic        inst_condition,
   output logic        end_inst,
   output logic        jmp_inst,
   output logic        hlt_inst,
   output logic [7:0]  jmp_address,
   output logic [7:0]  out_data,
   output logic        out_valid,
   output logic [2:0]  flags,
   output logic        illegal
);

   logic [7:0] opcode, imm;
   logic [1:0] rd, rs;
   logic       exec, step0, step1, step_late, out_accept;
   logic       unused_ir;

   logic [7:0] regs_q [NREGS];
   logic [7:0] regs_d [NREGS];
   logic [7:0] a_q, a_d, b_q, b_d;
   logic [2:0] flags_q, flags_d;
   logic [7:0] out_data_q, out_data_d;
   logic       out_valid_q, out_valid_d;
   logic       illegal_q, illegal_d;

   logic [7:0] alu_result;
   logic       alu_z, alu_c, alu_n;

   assign opcode    = ir[31:24];
   assign rd        = ir[17:16];
   assign rs        = ir[9:8];
   assign imm       = ir[7:0];
   assign unused_ir = ^{ir[23:18], ir[15:10]};

   // Reset forces every step inactive so the controls read 0 while it is held.
   assign exec       = !reset && (state == ST_EXEC);
   assign step0      = exec && clks[0];
   assign step1      = exec && clks[1];
   assign step_late  = exec && (|clks[15:1]);
   assign out_accept = step_late && (opcode == OP_OUT) && out_valid_q && out_ready;

   cpu_alu u_alu (
      .a      (a_q),
      .b      (b_q),
      .op     (opcode),
      .result (alu_result),
      .z      (alu_z),
      .c      (alu_c),
      .n      (alu_n)
   );

   always_comb begin
      inst_condition = 1'b0;
      end_inst       = 1'b0;
      jmp_inst       = 1'b0;
      hlt_inst       = 1'b0;
      jmp_address    = 8'd0;
      if (exec) begin
         inst_condition = 1'b1;
         case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: end_inst = step1;
            OP_JMP, OP_JZ, OP_JC, OP_JN: begin
               jmp_inst    = step0;
               end_inst    = step0;
               jmp_address = step0 ? imm : 8'd0;
               if (opcode == OP_JZ)      inst_condition = flags_q[FLAG_Z];
               else if (opcode == OP_JC) inst_condition = flags_q[FLAG_C];
               else if (opcode == OP_JN) inst_condition = flags_q[FLAG_N];
            end
            OP_OUT: end_inst = out_accept;
            OP_HLT: begin
               hlt_inst = step0;
               end_inst = step0;
            end
            default: end_inst = step0;
         endcase
      end
   end

   always_comb begin
      regs_d      = regs_q;
      a_d         = a_q;
      b_d         = b_q;
      flags_d     = flags_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      illegal_d   = illegal_q;
      if (step0) begin
         case (opcode)
            OP_LDI: regs_d[rd] = imm;
            OP_MOV: regs_d[rd] = regs_q[rs];
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
               a_d = regs_q[rd];
               b_d = regs_q[rs];
            end
            OP_OUT: begin
               out_data_d  = regs_q[rs];
               out_valid_d = 1'b1;
            end
            OP_NOP, OP_JMP, OP_JZ, OP_JC, OP_JN, OP_HLT: ;
            default: illegal_d = 1'b1;
         endcase
      end
      if (step1 && is_alu_op(opcode)) begin
         regs_d[rd]      = alu_result;
         flags_d[FLAG_Z] = alu_z;
         flags_d[FLAG_C] = alu_c;
         flags_d[FLAG_N] = alu_n;
      end
      if (out_accept) out_valid_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= 8'd0;
         a_q         <= 8'd0;
         b_q         <= 8'd0;
         flags_q     <= 3'd0;
         out_data_q  <= 8'd0;
         out_valid_q <= 1'b0;
         illegal_q   <= 1'b0;
      end else begin
         regs_q      <= regs_d;
         a_q         <= a_d;
         b_q         <= b_d;
         flags_q     <= flags_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         illegal_q   <= illegal_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign flags     = flags_q;
   assign illegal   = illegal_q;

endmodule

// File: tb/tb_cpu_exec.sv
// Directed-vector bench for cpu_exec: each task drives one scenario and checks
// hand-computed expectations inline.
module tb_cpu_exec;
   import cpu_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] ir;
   logic [15:0] clks;
   logic [1:0]  state;
   logic        out_ready;
   logic        inst_condition, end_inst, jmp_inst, hlt_inst;
   logic [7:0]  jmp_address, out_data;
   logic        out_valid, illegal;
   logic [2:0]  flags;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   cpu_exec #(.NREGS(4)) dut (
      .clk            (clk),
      .reset          (reset),
      .ir             (ir),
      .clks           (clks),
      .state          (state),
      .out_ready      (out_ready),
      .inst_condition (inst_condition),
      .end_inst       (end_inst),
      .jmp_inst       (jmp_inst),
      .hlt_inst       (hlt_inst),
      .jmp_address    (jmp_address),
      .out_data       (out_data),
      .out_valid      (out_valid),
      .flags          (flags),
      .illegal        (illegal)
   );

   function automatic logic [31:0] mk(input logic [7:0] op, input logic [1:0] rd,
                                      input logic [1:0] rs, input logic [7:0] imm);
      return {op, 6'b0, rd, 6'b0, rs, imm};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] i, input int n);
      ir    = i;
      clks  = 16'h0001 << n;
      state = ST_EXEC;
      #1;
      if (n == 0) $display("[TB] exec ir=%h op=%h", i, i[31:24]);
   endtask

   task automatic idle();
      state = ST_FETCH;
      clks  = 16'h0000;
   endtask

   task automatic run_alu(input logic [7:0] op, input logic [1:0] rd, input logic [1:0] rs);
      drive(mk(op, rd, rs, 8'h00), 0);
      tick();
      drive(mk(op, rd, rs, 8'h00), 1);
      tick();
      idle();
   endtask

   task automatic run_one(input logic [31:0] i);
      drive(i, 0);
      tick();
      idle();
   endtask

   task automatic read_reg(input logic [1:0] r, output logic [7:0] v);
      out_ready = 1'b0;
      drive(mk(OP_OUT, 2'd0, r, 8'h00), 0);
      tick();
      v = out_data;
      out_ready = 1'b1;
      drive(mk(OP_OUT, 2'd0, r, 8'h00), 1);
      tick();
      out_ready = 1'b0;
      idle();
   endtask

   task automatic test_reset();
      logic [7:0] v;
      reset = 1'b1;
      ir    = $urandom;
      clks  = 16'h0001;
      state = ST_EXEC;
      out_ready = 1'b1;
      #1;
      tests_run++; if ({end_inst, jmp_inst, hlt_inst, inst_condition} !== 4'b0000) begin tests_failed++; $display("FAIL reset_ctrl: got %b expected 0000", {end_inst, jmp_inst, hlt_inst, inst_condition}); end
      tests_run++; if (jmp_address !== 8'h00) begin tests_failed++; $display("FAIL reset_jaddr: got %h expected 00", jmp_address); end
      tick();
      reset = 1'b0;
      out_ready = 1'b0;
      idle();
      tests_run++; if ({flags, out_valid, illegal} !== 5'b0) begin tests_failed++; $display("FAIL reset_state: got %b expected 00000", {flags, out_valid, illegal}); end
      tests_run++; if (out_data !== 8'h00) begin tests_failed++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
      for (int r = 0; r < 4; r++) begin
         read_reg(r[1:0], v);
         tests_run++; if (v !== 8'h00) begin tests_failed++; $display("FAIL reset_reg%0d: got %h expected 00", r, v); end
      end
   endtask

   task automatic test_alu();
      logic [7:0] v;
      drive(mk(OP_LDI, 2'd1, 2'd0, 8'hF0), 0);
      tests_run++; if (end_inst !== 1'b1) begin tests_failed++; $display("FAIL ldi1_end: got %b expected 1", end_inst); end
      tick();
      drive(mk(OP_LDI, 2'd2, 2'd0, 8'h20), 0);
      tests_run++; if (end_inst !== 1'b1) begin tests_failed++; $display("FAIL ldi2_end: got %b expected 1", end_inst); end
      tick();
      drive(mk(OP_ADD, 2'd1, 2'd2, 8'h00), 0);
      tests_run++; if (end_inst !== 1'b0) begin tests_failed++; $display("FAIL add_end_s0: got %b expected 0", end_inst); end
      tick();
      drive(mk(OP_ADD, 2'd1, 2'd2, 8'h00), 1);
      tests_run++; if (end_inst !== 1'b1) begin tests_failed++; $display("FAIL add_end_s1: got %b expected 1", end_inst); end
      tick();
      idle();
      tests_run++; if (flags !== 3'b010) begin tests_failed++; $display("FAIL add_flags: got %b expected 010", flags); end
      read_reg(2'd1, v);
      tests_run++; if (v !== 8'h10) begin tests_failed++; $display("FAIL add_r1: got %h expected 10", v); end
      read_reg(2'd2, v);
      tests_run++; if (v !== 8'h20) begin tests_failed++; $display("FAIL add_r2: got %h expected 20", v); end
   endtask

   task automatic test_jump();
      run_alu(OP_SUB, 2'd2, 2'd2);
      tests_run++; if (flags !== 3'b001) begin tests_failed++; $display("FAIL sub_flags: got %b expected 001", flags); end
      drive(mk(OP_JZ, 2'd0, 2'd0, 8'h3C), 0);
      tests_run++; if ({jmp_inst, inst_condition, end_inst} !== 3'b111) begin tests_failed++; $display("FAIL jz_ctrl: got %b expected 111", {jmp_inst, inst_condition, end_inst}); end
      tests_run++; if (jmp_address !== 8'h3C) begin tests_failed++; $display("FAIL jz_addr: got %h expected 3c", jmp_address); end
      tick();
      drive(mk(OP_JC, 2'd0, 2'd0, 8'h3C), 0);
      tests_run++; if ({jmp_inst, inst_condition} !== 2'b10) begin tests_failed++; $display("FAIL jc_cond: got %b expected 10", {jmp_inst, inst_condition}); end
      tick();
      drive(mk(OP_JN, 2'd0, 2'd0, 8'h3C), 0);
      tests_run++; if (inst_condition !== 1'b0) begin tests_failed++; $display("FAIL jn_cond: got %b expected 0", inst_condition); end
      tick();
      drive(mk(OP_JMP, 2'd0, 2'd0, 8'hA5), 0);
      tests_run++; if ({jmp_inst, inst_condition, jmp_address} !== {2'b11, 8'hA5}) begin tests_failed++; $display("FAIL jmp: got %b/%h expected 11/a5", {jmp_inst, inst_condition}, jmp_address); end
      tick();
      drive(mk(OP_LDI, 2'd0, 2'd0, 8'h77), 0);
      tests_run++; if ({jmp_inst, inst_condition, jmp_address} !== {2'b01, 8'h00}) begin tests_failed++; $display("FAIL ldi_nonjump: got %b/%h expected 01/00", {jmp_inst, inst_condition}, jmp_address); end
      tick();
      idle();
   endtask

   task automatic test_out_stall();
      out_ready = 1'b1;
      drive(mk(OP_OUT, 2'd0, 2'd1, 8'h00), 0);
      tests_run++; if (end_inst !== 1'b0) begin tests_failed++; $display("FAIL out_end_s0: got %b expected 0", end_inst); end
      tick();
      out_ready = 1'b0;
      tests_run++; if ({out_valid, out_data} !== {1'b1, 8'h10}) begin tests_failed++; $display("FAIL out_issue: got %b/%h expected 1/10", out_valid, out_data); end
      for (int s = 1; s <= 3; s++) begin
         drive(mk(OP_OUT, 2'd0, 2'd1, 8'h00), s);
         tests_run++; if (end_inst !== 1'b0) begin tests_failed++; $display("FAIL out_stall_end_s%0d: got %b expected 0", s, end_inst); end
         tick();
         tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL out_stall_valid_s%0d: got %b expected 1", s, out_valid); end
      end
      out_ready = 1'b1;
      drive(mk(OP_OUT, 2'd0, 2'd1, 8'h00), 4);
      tests_run++; if (end_inst !== 1'b1) begin tests_failed++; $display("FAIL out_accept_end: got %b expected 1", end_inst); end
      tick();
      out_ready = 1'b0;
      idle();
      tests_run++; if ({out_valid, out_data} !== {1'b0, 8'h10}) begin tests_failed++; $display("FAIL out_done: got %b/%h expected 0/10", out_valid, out_data); end
   endtask

   task automatic test_reset_mid_out();
      logic [7:0] v;
      drive(mk(OP_LDI, 2'd3, 2'd0, 8'hAB), 0);
      tick();
      run_alu(OP_ADD, 2'd3, 2'd3);
      tests_run++; if (flags !== 3'b010) begin tests_failed++; $display("FAIL add_same_flags: got %b expected 010", flags); end
      drive(mk(OP_OUT, 2'd0, 2'd3, 8'h00), 0);
      tick();
      tests_run++; if ({out_valid, out_data} !== {1'b1, 8'h56}) begin tests_failed++; $display("FAIL add_same_out: got %b/%h expected 1/56", out_valid, out_data); end
      out_ready = 1'b1;
      reset = 1'b1;
      drive(mk(OP_OUT, 2'd0, 2'd3, 8'h00), 1);
      tests_run++; if (end_inst !== 1'b0) begin tests_failed++; $display("FAIL rst_out_end: got %b expected 0", end_inst); end
      tick();
      reset = 1'b0;
      out_ready = 1'b0;
      idle();
      tests_run++; if ({out_valid, flags} !== 4'b0000) begin tests_failed++; $display("FAIL rst_out_state: got %b/%b expected 0/000", out_valid, flags); end
      read_reg(2'd3, v);
      tests_run++; if (v !== 8'h00) begin tests_failed++; $display("FAIL rst_out_r3: got %h expected 00", v); end
      read_reg(2'd1, v);
      tests_run++; if (v !== 8'h00) begin tests_failed++; $display("FAIL rst_out_r1: got %h expected 00", v); end
   endtask

   task automatic test_illegal();
      tests_run++; if (illegal !== 1'b0) begin tests_failed++; $display("FAIL illegal_pre: got %b expected 0", illegal); end
      drive(mk(8'h55, 2'd0, 2'd0, 8'h00), 0);
      tests_run++; if (end_inst !== 1'b1) begin tests_failed++; $display("FAIL illegal_end: got %b expected 1", end_inst); end
      tick();
      idle();
      tests_run++; if (illegal !== 1'b1) begin tests_failed++; $display("FAIL illegal_set: got %b expected 1", illegal); end
      drive(mk(OP_HLT, 2'd0, 2'd0, 8'h00), 0);
      tests_run++; if ({hlt_inst, end_inst} !== 2'b11) begin tests_failed++; $display("FAIL hlt_ctrl: got %b expected 11", {hlt_inst, end_inst}); end
      tick();
      idle();
      tests_run++; if (illegal !== 1'b1) begin tests_failed++; $display("FAIL illegal_sticky: got %b expected 1", illegal); end
   endtask

   initial begin
      reset = 1'b1;
      ir = 32'h0;
      clks = 16'h0;
      state = ST_FETCH;
      out_ready = 1'b0;
      test_reset();
      test_alu();
      test_jump();
      test_out_stall();
      test_reset_mid_out();
      test_illegal();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
